// File: rtl/dmem_arb_pkg.sv
// Shared constants and types for the two-master data-memory arbiter.
package dmem_arb_pkg;

   localparam int DEF_AW       = 32;
   localparam int DEF_DW       = 32;
   localparam int DEF_MAX_HOLD = 4;
   localparam int HOLD_W       = 4;

   localparam logic M_CPU = 1'b0;
   localparam logic M_IO  = 1'b1;

   typedef struct packed {
      logic              req;
      logic              we;
      logic              lock;
      logic [DEF_AW-1:0] addr;
      logic [DEF_DW-1:0] wdata;
   } dmem_req_t;

   function automatic logic other_master(input logic m);
      return ~m;
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the data memory.
interface dmem_arbiter_if #(
   parameter int AW = dmem_arb_pkg::DEF_AW,
   parameter int DW = dmem_arb_pkg::DEF_DW
);
   logic          m0_req;
   logic          m0_we;
   logic          m0_lock;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata;
   logic          m0_gnt;
   logic          m0_rvalid;
   logic [DW-1:0] m0_rdata;

   logic          m1_req;
   logic          m1_we;
   logic          m1_lock;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata;
   logic          m1_gnt;
   logic          m1_rvalid;
   logic [DW-1:0] m1_rdata;

   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we;
   logic          mem_re;
   logic [DW-1:0] mem_rdata;

   logic          owner;
   logic          busy;

   modport slave (
      input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
      input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
      input  mem_rdata,
      output m0_gnt, m0_rvalid, m0_rdata,
      output m1_gnt, m1_rvalid, m1_rdata,
      output mem_addr, mem_wdata, mem_we, mem_re,
      output owner, busy
   );

   modport master (
      output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
      output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
      output mem_rdata,
      input  m0_gnt, m0_rvalid, m0_rdata,
      input  m1_gnt, m1_rvalid, m1_rdata,
      input  mem_addr, mem_wdata, mem_we, mem_re,
      input  owner, busy
   );

endinterface

// File: rtl/dmem_arbiter_rr_lock_sel.sv
// Round-robin grant selection with a bounded lock, plus owner/locked/hold_cnt state.
module rr_lock_sel
   import dmem_arb_pkg::*;
#(
   parameter int MAX_HOLD = DEF_MAX_HOLD
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic [1:0] lock,
   output logic [1:0] gnt,
   output logic       owner
);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

   logic              owner_q, owner_d;
   logic              locked_q, locked_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              lock_keep;
   logic              grant_vld;
   logic              sel;

   always_comb begin
      grant_vld  = 1'b0;
      sel        = M_CPU;
      owner_d    = owner_q;
      locked_d   = locked_q;
      hold_cnt_d = hold_cnt_q;
      lock_keep  = locked_q && req[owner_q] && (hold_cnt_q < HOLD_MAX);

      if (!reset) begin
         if (lock_keep) begin
            grant_vld = 1'b1;
            sel       = owner_q;
         end else if (req[M_CPU] ^ req[M_IO]) begin
            grant_vld = 1'b1;
            sel       = req[M_IO];
         end else if (req[M_CPU] && req[M_IO]) begin
            grant_vld = 1'b1;
            sel       = other_master(owner_q);
         end
      end

      if (grant_vld) begin
         owner_d  = sel;
         locked_d = lock[sel];
         // only back-to-back wins over a waiting master count towards the hold limit
         if ((sel == owner_q) && req[other_master(sel)]) begin
            hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? HOLD_MAX : hold_cnt_q + 1'b1;
         end else begin
            hold_cnt_d = '0;
         end
      end

      gnt = 2'b00;
      if (grant_vld) begin
         gnt[sel] = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         owner_q    <= M_IO;
         locked_q   <= 1'b0;
         hold_cnt_q <= '0;
      end else begin
         owner_q    <= owner_d;
         locked_q   <= locked_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   assign owner = owner_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data memory: grant, address/data mux,
// and one-cycle read-data return to the master that issued the read.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW       = DEF_AW,
   parameter int DW       = DEF_DW,
   parameter int MAX_HOLD = DEF_MAX_HOLD
) (
   input  logic          clock,
   input  logic          reset,
   dmem_arbiter_if.slave bus
);
   logic [1:0]    req;
   logic [1:0]    lock;
   logic [1:0]    gnt;
   logic          owner;
   logic          any_gnt;
   logic          sel_we;
   logic [AW-1:0] addr_mux;
   logic [DW-1:0] wdata_mux;
   logic          rd_pending_q, rd_pending_d;
   logic          rd_dst_q, rd_dst_d;
   logic          rd_out;
   logic          m0_rvalid;
   logic          m1_rvalid;

   assign req  = {bus.m1_req,  bus.m0_req};
   assign lock = {bus.m1_lock, bus.m0_lock};

   rr_lock_sel #(
      .MAX_HOLD (MAX_HOLD)
   ) u_rr_lock_sel (
      .clock (clock),
      .reset (reset),
      .req   (req),
      .lock  (lock),
      .gnt   (gnt),
      .owner (owner)
   );

   assign any_gnt = |gnt;

   // idle bus parks on master 0 so the memory pins do not toggle needlessly
   always_comb begin
      addr_mux  = bus.m0_addr;
      wdata_mux = bus.m0_wdata;
      sel_we    = bus.m0_we;
      if (gnt[M_IO]) begin
         addr_mux  = bus.m1_addr;
         wdata_mux = bus.m1_wdata;
         sel_we    = bus.m1_we;
      end
   end

   assign bus.mem_addr  = addr_mux;
   assign bus.mem_wdata = wdata_mux;
   assign bus.mem_we    = any_gnt && sel_we;
   assign bus.mem_re    = any_gnt && !sel_we;
   assign bus.m0_gnt    = gnt[M_CPU];
   assign bus.m1_gnt    = gnt[M_IO];
   assign bus.busy      = any_gnt;
   assign bus.owner     = owner;

   always_comb begin
      rd_pending_d = any_gnt && !sel_we;
      rd_dst_d     = rd_dst_q;
      if (any_gnt) begin
         rd_dst_d = gnt[M_IO];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_pending_q <= 1'b0;
         rd_dst_q     <= M_CPU;
      end else begin
         rd_pending_q <= rd_pending_d;
         rd_dst_q     <= rd_dst_d;
      end
   end

   // a read accepted just before reset must not be returned during the reset cycle
   assign rd_out    = rd_pending_q && !reset;
   assign m0_rvalid = rd_out && (rd_dst_q == M_CPU);
   assign m1_rvalid = rd_out && (rd_dst_q == M_IO);

   assign bus.m0_rvalid = m0_rvalid;
   assign bus.m1_rvalid = m1_rvalid;
   assign bus.m0_rdata  = m0_rvalid ? bus.mem_rdata : '0;
   assign bus.m1_rdata  = m1_rvalid ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Cycle-table bench for dmem_arbiter with a read-return scoreboard and a small memory model.
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

   localparam int MAX_HOLD = 4;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   dmem_arbiter_if #(.AW(DEF_AW), .DW(DEF_DW)) bus ();

   dmem_arbiter #(
      .AW       (DEF_AW),
      .DW       (DEF_DW),
      .MAX_HOLD (MAX_HOLD)
   ) u_dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic      rst;
      dmem_req_t m0;
      dmem_req_t m1;
      logic      g0;
      logic      g1;
      logic      own;
   } vec_t;

   typedef struct {
      logic        dst;
      logic [31:0] data;
   } sb_t;

   vec_t tbl[$];
   sb_t  sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_1234;
   endfunction

   always @(posedge clock) begin
      if (bus.mem_re === 1'b1) bus.mem_rdata <= mem_f(bus.mem_addr);
   end

   function automatic dmem_req_t rd(input logic [31:0] a, input logic lk);
      dmem_req_t r;
      r.req = 1'b1; r.we = 1'b0; r.lock = lk; r.addr = a; r.wdata = ~a;
      return r;
   endfunction

   function automatic dmem_req_t wr(input logic [31:0] a, input logic [31:0] d);
      dmem_req_t r;
      r.req = 1'b1; r.we = 1'b1; r.lock = 1'b0; r.addr = a; r.wdata = d;
      return r;
   endfunction

   function automatic dmem_req_t idle(input logic [31:0] a);
      dmem_req_t r;
      r.req = 1'b0; r.we = 1'b0; r.lock = 1'b0; r.addr = a; r.wdata = a ^ 32'hFFFF_0000;
      return r;
   endfunction

   function automatic vec_t row(input logic rst, input dmem_req_t a, input dmem_req_t b,
                                input logic g0, input logic g1, input logic own);
      vec_t v;
      v.rst = rst; v.m0 = a; v.m1 = b; v.g0 = g0; v.g1 = g1; v.own = own;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic apply(input vec_t v);
      sb_t         e;
      logic [31:0] e_addr, e_wdata;
      logic        e_we, e_re, rv0, rv1;
      @(negedge clock);
      reset        = v.rst;
      bus.m0_req   = v.m0.req;  bus.m0_we = v.m0.we;  bus.m0_lock = v.m0.lock;
      bus.m0_addr  = v.m0.addr; bus.m0_wdata = v.m0.wdata;
      bus.m1_req   = v.m1.req;  bus.m1_we = v.m1.we;  bus.m1_lock = v.m1.lock;
      bus.m1_addr  = v.m1.addr; bus.m1_wdata = v.m1.wdata;
      #2;
      e_addr  = v.g1 ? v.m1.addr  : v.m0.addr;
      e_wdata = v.g1 ? v.m1.wdata : v.m0.wdata;
      e_we    = (v.g0 && v.m0.we)  || (v.g1 && v.m1.we);
      e_re    = (v.g0 && !v.m0.we) || (v.g1 && !v.m1.we);
      chk("m0_gnt",    32'(bus.m0_gnt), 32'(v.g0));
      chk("m1_gnt",    32'(bus.m1_gnt), 32'(v.g1));
      chk("busy",      32'(bus.busy),   32'(v.g0 || v.g1));
      chk("owner",     32'(bus.owner),  32'(v.own));
      chk("mem_addr",  bus.mem_addr,    e_addr);
      chk("mem_wdata", bus.mem_wdata,   e_wdata);
      chk("mem_we",    32'(bus.mem_we), 32'(e_we));
      chk("mem_re",    32'(bus.mem_re), 32'(e_re));

      e   = '{dst: 1'b0, data: 32'h0};
      rv0 = 1'b0;
      rv1 = 1'b0;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         if (!v.rst) begin
            if (e.dst) rv1 = 1'b1;
            else       rv0 = 1'b1;
         end
      end
      chk("m0_rvalid", 32'(bus.m0_rvalid), 32'(rv0));
      chk("m1_rvalid", 32'(bus.m1_rvalid), 32'(rv1));
      chk("m0_rdata",  bus.m0_rdata, rv0 ? e.data : 32'h0);
      chk("m1_rdata",  bus.m1_rdata, rv1 ? e.data : 32'h0);

      if (!v.rst && e_re) begin
         sb_q.push_back('{dst: v.g1, data: mem_f(v.g1 ? v.m1.addr : v.m0.addr)});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected to finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] a;
      reset = 1'b1;
      bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_lock = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
      bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_lock = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
      bus.mem_rdata = '0;
      repeat (2) @(posedge clock);

      // reset, then contended reads: m0 first, then m1, data returns one cycle later
      tbl.push_back(row(1, rd(32'h10, 0),  rd(32'h20, 0),  0, 0, 1));
      tbl.push_back(row(0, rd(32'h10, 0),  rd(32'h20, 0),  1, 0, 1));
      tbl.push_back(row(0, idle(32'h14),   rd(32'h20, 0),  0, 1, 0));
      tbl.push_back(row(0, idle(32'hA0),   idle(32'hB0),   0, 0, 1));
      // lone m1 write
      tbl.push_back(row(0, idle(32'hA0),   wr(32'h40, 32'hDEADBEEF), 0, 1, 1));
      tbl.push_back(row(0, idle(32'hA4),   idle(32'hB4),   0, 0, 1));
      // m0 locks, m1 waits MAX_HOLD grants, then m1, then m0 again
      tbl.push_back(row(0, rd(32'h100, 1), idle(32'hB8),   1, 0, 1));
      tbl.push_back(row(0, rd(32'h104, 1), rd(32'h200, 0), 1, 0, 0));
      tbl.push_back(row(0, rd(32'h108, 1), rd(32'h200, 0), 1, 0, 0));
      tbl.push_back(row(0, rd(32'h10C, 1), rd(32'h200, 0), 1, 0, 0));
      tbl.push_back(row(0, rd(32'h110, 1), rd(32'h200, 0), 1, 0, 0));
      tbl.push_back(row(0, rd(32'h114, 1), rd(32'h200, 0), 0, 1, 0));
      tbl.push_back(row(0, rd(32'h114, 1), rd(32'h204, 0), 1, 0, 1));
      tbl.push_back(row(0, idle(32'hA8),   idle(32'hBC),   0, 0, 0));
      // back-to-back m0 reads
      tbl.push_back(row(0, rd(32'h0, 0),  idle(32'hC0),   1, 0, 0));
      tbl.push_back(row(0, rd(32'h4, 0),  idle(32'hC0),   1, 0, 0));
      tbl.push_back(row(0, rd(32'h8, 0),  idle(32'hC0),   1, 0, 0));
      tbl.push_back(row(0, idle(32'hAC),  idle(32'hC4),   0, 0, 0));
      // reset right after an accepted m1 read
      tbl.push_back(row(0, idle(32'hB0),   rd(32'h300, 0), 0, 1, 0));
      tbl.push_back(row(1, rd(32'h10, 0),  rd(32'h20, 0),  0, 0, 1));
      tbl.push_back(row(0, rd(32'h10, 0),  rd(32'h20, 0),  1, 0, 1));
      // m0 drops req after its grant
      tbl.push_back(row(0, idle(32'h10),   idle(32'hC8),   0, 0, 0));
      tbl.push_back(row(0, idle(32'h18),   idle(32'hCC),   0, 0, 0));
      // contended writes
      tbl.push_back(row(0, wr(32'h44, 32'h12345678), wr(32'h48, 32'hCAFEF00D), 0, 1, 0));
      tbl.push_back(row(0, idle(32'hD0),   idle(32'hD4),   0, 0, 1));

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

      // one read per cycle throughput from m0
      for (int i = 0; i < 8; i++) begin
         a = $urandom & 32'h0000_FFFC;
         apply(row(0, rd(a, 0), idle(32'hE0), 1, 0, (i == 0) ? 1'b1 : 1'b0));
      end
      apply(row(0, idle(32'hE4), idle(32'hE8), 0, 0, 0));

      // m1 locks; m0 waits exactly MAX_HOLD extension grants
      apply(row(0, idle(32'hF0), rd(32'h500, 1), 0, 1, 0));
      for (int k = 0; k < MAX_HOLD; k++) begin
         apply(row(0, rd(32'h600 + 32'(4 * k), 0), rd(32'h504 + 32'(4 * k), 1), 0, 1, 1));
      end
      apply(row(0, rd(32'h700, 0), rd(32'h580, 1), 1, 0, 1));
      apply(row(0, idle(32'hF4), idle(32'hF8), 0, 0, 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
